// File: rtl/led_seq_pkg.sv
// Shared types for the LED bounce sequencer: pattern modes, bounce direction
// and the LSB one-hot reset pattern.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_BOUNCE = 2'b00,
        MODE_ROT_L  = 2'b01,
        MODE_ROT_R  = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_t;

    typedef enum logic {
        SHIFT_UP   = 1'b0,
        SHIFT_DOWN = 1'b1
    } dir_t;

    // Sliced down to NUM_LEDS by the user; widest legal pattern is 32 LEDs.
    localparam logic [31:0] LED_RESET_PATTERN = 32'h0000_0001;

endpackage

// File: rtl/led_bounce_sequencer_edge_sync.sv
// Synchronizes an asynchronous level into clk and flags its rising edges
// with a single-cycle rise_out pulse.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise_out
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_out = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/led_bounce_sequencer.sv
// Steps a one-hot LED pattern on each rising edge of the divided slow clock:
// bounce between the ends, rotate left/right, or hold.
module led_bounce_sequencer
    import led_seq_pkg::*;
#(
    parameter int NUM_LEDS    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                slow_clk_in,
    input  logic                enable,
    input  logic [1:0]          mode,
    output logic [NUM_LEDS-1:0] led_out,
    output logic                step_tick,
    output logic                dir_out
);

    logic                rise;
    mode_t               mode_sel;
    dir_t                state_q;
    logic [NUM_LEDS-1:0] led_q;
    logic                tick_q;
    logic [NUM_LEDS-1:0] rot_l_d;
    logic [NUM_LEDS-1:0] rot_r_d;

    edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (slow_clk_in),
        .rise_out (rise)
    );

    assign mode_sel = mode_t'(mode);
    assign rot_l_d  = {led_q[NUM_LEDS-2:0], led_q[NUM_LEDS-1]};
    assign rot_r_d  = {led_q[0], led_q[NUM_LEDS-1:1]};

    // Pattern, direction and step pulse are all registered in the tick cycle,
    // so led_out and step_tick change together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_q   <= LED_RESET_PATTERN[NUM_LEDS-1:0];
            state_q <= SHIFT_UP;
            tick_q  <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            if (rise && enable) begin
                case (mode_sel)
                    MODE_BOUNCE: begin
                        tick_q <= 1'b1;
                        if (state_q == SHIFT_UP) begin
                            if (led_q[NUM_LEDS-1]) begin
                                state_q <= SHIFT_DOWN;
                                led_q   <= led_q >> 1;
                            end else begin
                                led_q   <= led_q << 1;
                            end
                        end else begin
                            if (led_q[0]) begin
                                state_q <= SHIFT_UP;
                                led_q   <= led_q << 1;
                            end else begin
                                led_q   <= led_q >> 1;
                            end
                        end
                    end
                    MODE_ROT_L: begin
                        tick_q <= 1'b1;
                        led_q  <= rot_l_d;
                    end
                    MODE_ROT_R: begin
                        tick_q <= 1'b1;
                        led_q  <= rot_r_d;
                    end
                    MODE_HOLD: begin
                        tick_q <= 1'b0;
                    end
                    default: begin
                        tick_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign led_out   = led_q;
    assign step_tick = tick_q;
    assign dir_out   = (state_q == SHIFT_DOWN);

endmodule

// File: tb/tb_led_bounce_sequencer.sv
// Directed bench for led_bounce_sequencer: LED position model plus a
// scoreboard queue of expected patterns popped on every step_tick.
module tb_led_bounce_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       slow_clk_in = 1'b0;
    logic       enable = 1'b1;
    logic [1:0] mode = 2'b00;
    logic [7:0] led_out;
    logic       step_tick;
    logic       dir_out;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] led;
        logic       dir;
    } exp_t;

    exp_t sb_q[$];

    int   m_pos = 0;
    logic m_dir = 1'b0;

    led_bounce_sequencer #(
        .NUM_LEDS    (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .slow_clk_in (slow_clk_in),
        .enable      (enable),
        .mode        (mode),
        .led_out     (led_out),
        .step_tick   (step_tick),
        .dir_out     (dir_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_led();
        return 8'(32'd1 << m_pos);
    endfunction

    task automatic model_tick(output logic es);
        es = 1'b0;
        if (enable) begin
            case (mode)
                2'b00: begin
                    es = 1'b1;
                    if (!m_dir) begin
                        if (m_pos == 7) begin m_dir = 1'b1; m_pos = 6; end
                        else m_pos++;
                    end else begin
                        if (m_pos == 0) begin m_dir = 1'b0; m_pos = 1; end
                        else m_pos--;
                    end
                end
                2'b01: begin es = 1'b1; m_pos = (m_pos + 1) % 8; end
                2'b10: begin es = 1'b1; m_pos = (m_pos + 7) % 8; end
                default: es = 1'b0;
            endcase
        end
    endtask

    // Every step pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && step_tick) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_step", 32'(step_tick), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_led", 32'(led_out), 32'(e.led));
                chk("sb_dir", 32'(dir_out), 32'(e.dir));
            end
        end
    end

    task automatic slow_edge();
        logic es;
        exp_t e;
        model_tick(es);
        if (es) begin
            e.led = exp_led();
            e.dir = m_dir;
            sb_q.push_back(e);
        end
        @(negedge clk) slow_clk_in = 1'b1;
        @(negedge clk) chk("lat1_step", 32'(step_tick), 32'd0);
        @(negedge clk) chk("lat2_step", 32'(step_tick), 32'd0);
        @(negedge clk);
        chk("lat3_step", 32'(step_tick), 32'(es));
        chk("lat3_led", 32'(led_out), 32'(exp_led()));
        chk("lat3_dir", 32'(dir_out), 32'(m_dir));
        @(negedge clk) chk("pulse_width", 32'(step_tick), 32'd0);
        slow_clk_in = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int   cnt;
        int   guard;
        logic es;
        exp_t e;
        logic [7:0] held;

        // Reset state while reset is held
        @(negedge clk);
        chk("rst_led", 32'(led_out), 32'h01);
        chk("rst_dir", 32'(dir_out), 32'd0);
        chk("rst_step", 32'(step_tick), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Bounce sweep, 9 ticks
        for (int i = 0; i < 9; i++) slow_edge();
        chk("sweep_led", 32'(led_out), 32'h20);
        chk("sweep_dir", 32'(dir_out), 32'd1);

        // slow_clk_in held high for 100 cycles yields one tick
        model_tick(es);
        e.led = exp_led(); e.dir = m_dir; sb_q.push_back(e);
        @(negedge clk) slow_clk_in = 1'b1;
        cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (step_tick) cnt++;
        end
        chk("hold_high_ticks", 32'(cnt), 32'd1);
        chk("hold_high_led", 32'(led_out), 32'h10);
        slow_clk_in = 1'b0;
        repeat (3) @(negedge clk);

        // Rotate left up to the MSB, then wrap
        mode = 2'b01;
        guard = 0;
        while (m_pos != 7 && guard < 10) begin slow_edge(); guard++; end
        chk("rot_at_msb", 32'(led_out), 32'h80);
        slow_edge();
        chk("rotl_wrap", 32'(led_out), 32'h01);
        chk("rotl_dir", 32'(dir_out), 32'd1);
        mode = 2'b10;
        slow_edge();
        chk("rotr_wrap", 32'(led_out), 32'h80);
        chk("rotr_dir", 32'(dir_out), 32'd1);

        // Disabled edges are dropped, not queued
        enable = 1'b0;
        repeat (3) slow_edge();
        chk("disabled_led", 32'(led_out), 32'h80);
        enable = 1'b1;
        slow_edge();
        chk("enable_one_step", 32'(led_out), 32'h40);
        repeat (6) @(negedge clk);
        chk("no_queued_steps", 32'(led_out), 32'h40);

        // Reach SHIFT_UP state, then rotate the light onto the MSB
        mode = 2'b00;
        guard = 0;
        while (!(m_pos == 1 && m_dir == 1'b0) && guard < 20) begin slow_edge(); guard++; end
        chk("bounce_low_turn", 32'(led_out), 32'h02);
        mode = 2'b01;
        guard = 0;
        while (m_pos != 7 && guard < 10) begin slow_edge(); guard++; end
        chk("up_at_msb_dir", 32'(dir_out), 32'd0);

        // Hold mode: no change, no step
        mode = 2'b11;
        held = led_out;
        repeat (4) slow_edge();
        chk("hold_led", 32'(led_out), 32'(held));

        // Back to bounce with SHIFT_UP stored and MSB lit
        mode = 2'b00;
        slow_edge();
        chk("resume_led", 32'(led_out), 32'h40);
        chk("resume_dir", 32'(dir_out), 32'd1);
        slow_edge();
        chk("pre_reset_led", 32'(led_out), 32'h20);

        // Async reset mid-sweep with an edge in flight
        @(negedge clk) slow_clk_in = 1'b1;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_led", 32'(led_out), 32'h01);
        chk("async_rst_dir", 32'(dir_out), 32'd0);
        chk("async_rst_step", 32'(step_tick), 32'd0);
        slow_clk_in = 1'b0;
        m_pos = 0; m_dir = 1'b0;
        sb_q.delete();
        @(negedge clk) reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("post_rst_idle", 32'(led_out), 32'h01);
        slow_edge();
        chk("post_rst_first", 32'(led_out), 32'h02);

        repeat (4) @(negedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
